// File: rtl/steering_pkg.sv
// Shared types and defaults for the multi-axis joystick-to-PWM steering block.
// slew_toward() moves a duty value toward a target by a bounded step per PWM period.
package steering_pkg;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_POS  = 2'd1,
        DIR_NEG  = 2'd2
    } dir_t;

    localparam int DEF_N_AXIS       = 2;
    localparam int DEF_VAL_W        = 11;
    localparam int DEF_CENTER       = 512;
    localparam int DEF_DEADBAND     = 16;
    localparam int DEF_SCALE        = 40;
    localparam int DEF_TICK_DIV     = 100;
    localparam int DEF_PERIOD_TICKS = 20000;
    localparam int DEF_SLEW_STEP    = 0;

    // A step of 0 means unlimited: jump straight to the target.
    function automatic int slew_toward(input int cur, input int tgt, input int step);
        int res;
        if (step == 0) begin
            res = tgt;
        end else if (tgt > cur) begin
            res = (tgt - cur > step) ? cur + step : tgt;
        end else begin
            res = (cur - tgt > step) ? cur - step : tgt;
        end
        return res;
    endfunction

endpackage

// File: rtl/steering_axis_ch.sv
// One steering axis: converts a joystick sample into a target duty/direction, applies it
// at period boundaries with slew limiting and break-before-reverse, and drives the PWM pair.
module steering_axis_ch
    import steering_pkg::*;
#(
    parameter int VAL_W        = DEF_VAL_W,
    parameter int CENTER       = DEF_CENTER,
    parameter int DEADBAND     = DEF_DEADBAND,
    parameter int SCALE        = DEF_SCALE,
    parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
    parameter int SLEW_STEP    = DEF_SLEW_STEP,
    parameter int DUTY_W       = $clog2(PERIOD_TICKS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_boundary,
    input  logic [DUTY_W-1:0] i_pc,
    input  logic [VAL_W-1:0]  i_x,
    input  logic              i_valid,
    output logic              o_pwm_pos,
    output logic              o_pwm_neg
);

    localparam logic signed [VAL_W:0] CENTER_S = (VAL_W + 1)'(CENTER);

    logic signed [VAL_W:0] w_diff;
    logic [VAL_W:0]        w_mag;
    logic [31:0]           w_mag_ext;
    logic [31:0]           w_prod;
    logic [DUTY_W-1:0]     w_tduty_new;
    dir_t                  w_tdir_new;
    logic [DUTY_W-1:0]     w_step_target;
    logic [DUTY_W-1:0]     w_step_zero;

    logic [DUTY_W-1:0]     r_tduty;
    dir_t                  r_tdir;
    logic [DUTY_W-1:0]     r_applied;
    dir_t                  r_dir;
    logic                  r_pwm_pos;
    logic                  r_pwm_neg;

    assign w_diff    = $signed({1'b0, i_x}) - CENTER_S;
    assign w_mag     = w_diff[VAL_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_mag_ext = 32'(w_mag);
    assign w_prod    = (w_mag_ext - 32'(DEADBAND)) * 32'(SCALE);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        w_tduty_new = '0;
        w_tdir_new  = DIR_NONE;
        if (w_mag_ext > 32'(DEADBAND)) begin
            w_tdir_new  = w_diff[VAL_W] ? DIR_NEG : DIR_POS;
            w_tduty_new = (w_prod >= 32'(PERIOD_TICKS)) ? DUTY_W'(PERIOD_TICKS)
                                                         : w_prod[DUTY_W-1:0];
        end
    end

    assign w_step_target = DUTY_W'(slew_toward(int'(r_applied), int'(r_tduty), SLEW_STEP));
    assign w_step_zero   = DUTY_W'(slew_toward(int'(r_applied), 0, SLEW_STEP));

    // Targets survive en=0 so the drive resumes where it was once re-enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tduty <= '0;
            r_tdir  <= DIR_NONE;
        end else if (i_valid) begin
            r_tduty <= w_tduty_new;
            r_tdir  <= w_tdir_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_applied <= '0;
            r_dir     <= DIR_NONE;
        end else if (i_boundary) begin
            if (r_dir == r_tdir || r_applied == '0) begin
                if (r_tdir != DIR_NONE) begin
                    r_dir <= r_tdir;
                end
                r_applied <= w_step_target;
            end else begin
                // Direction change: drain to zero first, keeping the old direction.
                r_applied <= w_step_zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_pos <= 1'b0;
            r_pwm_neg <= 1'b0;
        end else begin
            r_pwm_pos <= i_en && (r_dir == DIR_POS) && (i_pc < r_applied);
            r_pwm_neg <= i_en && (r_dir == DIR_NEG) && (i_pc < r_applied);
        end
    end

    assign o_pwm_pos = r_pwm_pos;
    assign o_pwm_neg = r_pwm_neg;

endmodule

// File: rtl/steering_pwm_mc.sv
// N-axis joystick-to-PWM drive generator: shared prescaler/period timebase plus one
// steering_axis_ch per axis, each producing a bidirectional pos/neg PWM pair.
module steering_pwm_mc
    import steering_pkg::*;
#(
    parameter int N_AXIS       = DEF_N_AXIS,
    parameter int VAL_W        = DEF_VAL_W,
    parameter int CENTER       = DEF_CENTER,
    parameter int DEADBAND     = DEF_DEADBAND,
    parameter int SCALE        = DEF_SCALE,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
    parameter int SLEW_STEP    = DEF_SLEW_STEP
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [N_AXIS*VAL_W-1:0] x_val,
    input  logic [N_AXIS-1:0]       x_valid,
    output logic [N_AXIS-1:0]       pwm_pos,
    output logic [N_AXIS-1:0]       pwm_neg,
    output logic                    period_start
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DUTY_W  = $clog2(PERIOD_TICKS + 1);

    logic [PRESC_W-1:0] r_presc;
    logic [DUTY_W-1:0]  r_pc;
    logic               r_period_start;
    logic               w_tick;
    logic               w_boundary;

    assign w_tick     = (r_presc == PRESC_W'(TICK_DIV - 1));
    assign w_boundary = en && w_tick && (r_pc == DUTY_W'(PERIOD_TICKS - 1));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all channels see the pre-edge pc.
        if (rst || !en) begin
            r_presc        <= '0;
            r_pc           <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_boundary;
            if (w_tick) begin
                r_presc <= '0;
                r_pc    <= (r_pc == DUTY_W'(PERIOD_TICKS - 1)) ? '0 : r_pc + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    assign period_start = r_period_start;

    for (genvar g = 0; g < N_AXIS; g++) begin : g_axis
        steering_axis_ch #(
            .VAL_W       (VAL_W),
            .CENTER      (CENTER),
            .DEADBAND    (DEADBAND),
            .SCALE       (SCALE),
            .PERIOD_TICKS(PERIOD_TICKS),
            .SLEW_STEP   (SLEW_STEP),
            .DUTY_W      (DUTY_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_en      (en),
            .i_boundary(w_boundary),
            .i_pc      (r_pc),
            .i_x       (x_val[g*VAL_W +: VAL_W]),
            .i_valid   (x_valid[g]),
            .o_pwm_pos (pwm_pos[g]),
            .o_pwm_neg (pwm_neg[g])
        );
    end

endmodule

// File: tb/tb_steering_pwm_mc.sv
// Directed bench for steering_pwm_mc: a short timebase (2 clk/tick, 200 ticks/period,
// SCALE 2) with one unlimited-slew instance (A) and one SLEW_STEP=50 instance (B).
module tb_steering_pwm_mc;

    localparam int VAL_W        = 11;
    localparam int TICK_DIV     = 2;
    localparam int PERIOD_TICKS = 200;
    localparam int SCALE        = 2;
    localparam int P_CYC        = TICK_DIV * PERIOD_TICKS;

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic [2*VAL_W-1:0]   xa_val, xb_val;
    logic [1:0]           xa_valid, xb_valid;
    logic [1:0]           pwm_pos_a, pwm_neg_a, pwm_pos_b, pwm_neg_b;
    logic                 ps_a, ps_b;

    int n_tests = 0;
    int n_fail  = 0;
    int hp[2];
    int hn[2];

    steering_pwm_mc #(
        .N_AXIS(2), .VAL_W(VAL_W), .CENTER(512), .DEADBAND(16), .SCALE(SCALE),
        .TICK_DIV(TICK_DIV), .PERIOD_TICKS(PERIOD_TICKS), .SLEW_STEP(0)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en), .x_val(xa_val), .x_valid(xa_valid),
        .pwm_pos(pwm_pos_a), .pwm_neg(pwm_neg_a), .period_start(ps_a)
    );

    steering_pwm_mc #(
        .N_AXIS(2), .VAL_W(VAL_W), .CENTER(512), .DEADBAND(16), .SCALE(SCALE),
        .TICK_DIV(TICK_DIV), .PERIOD_TICKS(PERIOD_TICKS), .SLEW_STEP(50)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .x_val(xb_val), .x_valid(xb_valid),
        .pwm_pos(pwm_pos_b), .pwm_neg(pwm_neg_b), .period_start(ps_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input int ax, input logic [VAL_W-1:0] v, input bit vld);
        if (sel) begin
            xb_val[ax*VAL_W +: VAL_W] = v;
            xb_valid[ax]              = vld;
        end else begin
            xa_val[ax*VAL_W +: VAL_W] = v;
            xa_valid[ax]              = vld;
        end
    endtask

    task automatic wait_start(input bit sel);
        int n = 0;
        while (((sel ? ps_b : ps_a) !== 1'b1) && n < 3*P_CYC) begin
            @(negedge clk);
            n++;
        end
        check("period_start_wait", int'(sel ? ps_b : ps_a), 1);
    endtask

    // Called right after a release of rst or en: first boundary must be one full period later.
    task automatic wait_first(input string tag);
        int k = 0;
        int highs = 0;
        while (ps_a !== 1'b1 && k < 3*P_CYC) begin
            @(negedge clk);
            k++;
            if (|{pwm_pos_a, pwm_neg_a, pwm_pos_b, pwm_neg_b}) highs++;
        end
        check({tag, "_first_boundary"}, k, P_CYC);
        check({tag, "_idle_low"}, highs, 0);
    endtask

    // Counts high cycles of one whole period of the selected instance, optionally
    // strobing one axis at cycle stb_at of that period.
    task automatic measure(input bit sel, input bit stb, input int stb_at,
                           input int stb_ax, input logic [VAL_W-1:0] stb_val);
        logic [1:0] p, n;
        int both;
        wait_start(sel);
        both = 0;
        for (int a = 0; a < 2; a++) begin
            hp[a] = 0;
            hn[a] = 0;
        end
        for (int i = 0; i < P_CYC; i++) begin
            if (stb && i == stb_at)     drive(sel, stb_ax, stb_val, 1'b1);
            if (stb && i == stb_at + 1) drive(sel, stb_ax, stb_val, 1'b0);
            @(negedge clk);
            p = sel ? pwm_pos_b : pwm_pos_a;
            n = sel ? pwm_neg_b : pwm_neg_a;
            for (int a = 0; a < 2; a++) begin
                hp[a] += int'(p[a]);
                hn[a] += int'(n[a]);
            end
            if ((p & n) != 2'b00) both++;
        end
        xa_valid = '0;
        xb_valid = '0;
        check("pos_neg_exclusive", both, 0);
        check("period_start_spacing", int'(sel ? ps_b : ps_a), 1);
    endtask

    task automatic expect4(input string tag, input int p0, input int n0, input int p1, input int n1);
        check({tag, "_pos0"}, hp[0], p0);
        check({tag, "_neg0"}, hn[0], n0);
        check({tag, "_pos1"}, hp[1], p1);
        check({tag, "_neg1"}, hn[1], n1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int highs;
        rst      = 1'b1;
        en       = 1'b1;
        xa_val   = {2{11'd512}};
        xb_val   = {2{11'd512}};
        xa_valid = '0;
        xb_valid = '0;
        repeat (5) @(negedge clk);
        check("reset_outputs", int'({pwm_pos_a, pwm_neg_a, pwm_pos_b, pwm_neg_b, ps_a, ps_b}), 0);
        rst = 1'b0;
        wait_first("reset");

        // Instance A, unlimited slew: each call shows the previous strobe's effect.
        measure(0, 1, 10, 0, 11'd528);  expect4("a1_idle",       0,   0, 0,   0);
        measure(0, 1, 10, 0, 11'd529);  expect4("a2_db528",      0,   0, 0,   0);
        measure(0, 1, 10, 0, 11'd496);  expect4("a3_529",        4,   0, 0,   0);
        measure(0, 1, 10, 0, 11'd495);  expect4("a4_db496",      0,   0, 0,   0);
        measure(0, 1, 10, 0, 11'd560);  expect4("a5_495",        0,   4, 0,   0);
        measure(0, 1, 10, 1, 11'd450);  expect4("a6_rev_gap",    0,   0, 0,   0);
        measure(0, 1, 10, 0, 11'd627);  expect4("a7_560_450",  128,   0, 0, 184);
        measure(0, 1, 10, 0, 11'd628);  expect4("a8_627",      396,   0, 0, 184);
        measure(0, 1, 10, 0, 11'd1023); expect4("a9_628_sat",  400,   0, 0, 184);
        measure(0, 1, P_CYC-1, 0, 11'd0);
                                        expect4("a10_1023",    400,   0, 0, 184);
        measure(0, 0, 0, 0, 11'd0);     expect4("a11_bnd_stb", 400,   0, 0, 184);
        measure(0, 0, 0, 0, 11'd0);     expect4("a12_rev_gap",   0,   0, 0, 184);
        measure(0, 0, 0, 0, 11'd0);     expect4("a13_x0",        0, 400, 0, 184);

        // Enable drop in the middle of a pulse.
        repeat (50) @(negedge clk);
        check("en_mid_pulse_high", int'(pwm_neg_a), 3);
        en = 1'b0;
        @(negedge clk);
        check("en_drop_low", int'({pwm_pos_a, pwm_neg_a}), 0);
        highs = 0;
        repeat (30) begin
            @(negedge clk);
            if (|{pwm_pos_a, pwm_neg_a, pwm_pos_b, pwm_neg_b, ps_a, ps_b}) highs++;
        end
        check("en_off_idle", highs, 0);
        en = 1'b1;
        wait_first("en_restart");
        measure(0, 0, 0, 0, 11'd0);     expect4("a14_retained",  0, 400, 0, 184);

        // Instance B, SLEW_STEP=50 ticks per period.
        measure(1, 1, 10, 0, 11'd1023); expect4("b1_idle",       0,   0, 0, 0);
        measure(1, 0, 0, 0, 11'd0);     expect4("b2_slew50",   100,   0, 0, 0);
        measure(1, 0, 0, 0, 11'd0);     expect4("b3_slew100",  200,   0, 0, 0);
        measure(1, 0, 0, 0, 11'd0);     expect4("b4_slew150",  300,   0, 0, 0);
        measure(1, 1, 10, 0, 11'd560);  expect4("b5_slew200",  400,   0, 0, 0);
        measure(1, 0, 0, 0, 11'd0);     expect4("b6_down150",  300,   0, 0, 0);
        measure(1, 0, 0, 0, 11'd0);     expect4("b7_down100",  200,   0, 0, 0);
        measure(1, 1, 10, 0, 11'd0);    expect4("b8_down64",   128,   0, 0, 0);
        measure(1, 0, 0, 0, 11'd0);     expect4("b9_drain14",   28,   0, 0, 0);
        measure(1, 0, 0, 0, 11'd0);     expect4("b10_gap",       0,   0, 0, 0);
        measure(1, 0, 0, 0, 11'd0);     expect4("b11_neg50",     0, 100, 0, 0);
        measure(1, 0, 0, 0, 11'd0);     expect4("b12_neg100",    0, 200, 0, 0);

        // Reset in the middle of a pulse.
        repeat (20) @(negedge clk);
        check("rst_pre_b", int'(pwm_neg_b), 1);
        check("rst_pre_a", int'(pwm_neg_a), 3);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_low", int'({pwm_pos_a, pwm_neg_a, pwm_pos_b, pwm_neg_b, ps_a, ps_b}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_first("rst_restart");
        measure(0, 0, 0, 0, 11'd0);     expect4("a15_after_rst", 0, 0, 0, 0);
        measure(1, 0, 0, 0, 11'd0);     expect4("b13_after_rst", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
